// File: rtl/cache_controller_pkg.sv
// Shared constants and FSM encoding for the data-cache initiator controller.
package cache_controller_pkg;

  localparam int unsigned DEF_BASE_ADDR = 1024;
  localparam int unsigned TAG_W         = 11;
  localparam int unsigned INDEX_W       = 6;
  localparam int unsigned OFFSET_W      = 1;
  localparam int unsigned LINE_W        = 64;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned CACHE_ADDR_W  = TAG_W + INDEX_W + OFFSET_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_FILL    = 2'd2;
  localparam logic [1:0] ST_WR_WAIT = 2'd3;

endpackage

// File: rtl/cache_controller.sv
// Turns pipeline loads/stores into cache hits, SRAM line fills (read miss) or
// SRAM write-throughs (store, no-write-allocate with invalidate-on-hit).
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned SRAM_ADDR_W = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    MEM_R_EN,
  input  logic                    MEM_W_EN,
  input  logic [31:0]             address,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    ready,
  output logic [17:0]             cache_address,
  input  logic [31:0]             cache_ReadData,
  input  logic                    cache_isHit,
  output logic                    cache_MEM_R_EN,
  output logic                    cache_writeEn,
  output logic [63:0]             cache_WriteData,
  output logic                    cache_invalidate,
  output logic                    cache_LRU_update,
  output logic [SRAM_ADDR_W-1:0]  sram_address,
  output logic [31:0]             sram_wdata,
  output logic                    sram_read_en,
  output logic                    sram_write_en,
  input  logic [63:0]             sram_rdata,
  input  logic                    sram_ready
);

  logic [1:0]              state_q, state_d;
  logic [LINE_W-1:0]       line_buf_q, line_buf_d;
  logic [CACHE_ADDR_W-1:0] word_q, word_d;
  logic [WORD_W-1:0]       wdata_q, wdata_d;

  logic [31:0]             eff;
  logic [CACHE_ADDR_W-1:0] req_word;
  logic [CACHE_ADDR_W-1:0] cur_word;
  logic                    unused_eff_bits;

  // Address captured at request acceptance so a dropped request still completes coherently.
  assign eff             = address - 32'(BASE_ADDR);
  assign req_word        = eff[19:2];
  assign unused_eff_bits = ^{eff[31:20], eff[1:0]};
  assign cur_word        = (state_q == ST_IDLE) ? req_word : word_q;

  assign cache_address    = cur_word;
  assign sram_address     = SRAM_ADDR_W'(cur_word[CACHE_ADDR_W-1:1]);
  assign sram_wdata       = (state_q == ST_IDLE) ? wdata : wdata_q;
  assign cache_WriteData  = line_buf_q;
  assign cache_LRU_update = 1'b0;

  // Next-state, datapath and strobe decode.
  always_comb begin
    state_d          = state_q;
    line_buf_d       = line_buf_q;
    word_d           = word_q;
    wdata_d          = wdata_q;
    rdata            = '0;
    ready            = 1'b0;
    cache_MEM_R_EN   = 1'b0;
    cache_writeEn    = 1'b0;
    cache_invalidate = 1'b0;
    sram_read_en     = 1'b0;
    sram_write_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (MEM_W_EN) begin
          cache_invalidate = 1'b1;
          word_d           = req_word;
          wdata_d          = wdata;
          state_d          = ST_WR_WAIT;
        end else if (MEM_R_EN) begin
          cache_MEM_R_EN = 1'b1;
          if (cache_isHit) begin
            ready = 1'b1;
            rdata = cache_ReadData;
          end else begin
            word_d  = req_word;
            state_d = ST_RD_WAIT;
          end
        end else begin
          ready = 1'b1;
        end
      end

      ST_RD_WAIT: begin
        sram_read_en = 1'b1;
        if (sram_ready) begin
          line_buf_d = sram_rdata;
          state_d    = ST_FILL;
        end
      end

      ST_FILL: begin
        cache_writeEn = 1'b1;
        ready         = 1'b1;
        rdata         = word_q[0] ? line_buf_q[63:32] : line_buf_q[31:0];
        state_d       = ST_IDLE;
      end

      ST_WR_WAIT: begin
        sram_write_en = 1'b1;
        if (sram_ready) begin
          ready   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      line_buf_q <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      line_buf_q <= line_buf_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: emulated 2-way cache and SRAM, plus an LRU/memory reference model.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [17:0] cache_address;
  logic [31:0] cache_ReadData;
  logic        cache_isHit, cache_MEM_R_EN, cache_writeEn, cache_invalidate, cache_LRU_update;
  logic [63:0] cache_WriteData;
  logic [16:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read_en, sram_write_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_controller #(.BASE_ADDR(1024), .SRAM_ADDR_W(17)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .cache_address(cache_address), .cache_ReadData(cache_ReadData),
    .cache_isHit(cache_isHit), .cache_MEM_R_EN(cache_MEM_R_EN),
    .cache_writeEn(cache_writeEn), .cache_WriteData(cache_WriteData),
    .cache_invalidate(cache_invalidate), .cache_LRU_update(cache_LRU_update),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  // Backing-store contents before any store touches a line.
  function automatic logic [63:0] line_init(input int la);
    if (la == 1) return 64'hAAAA0002_BBBB0001;
    return {32'(la) * 32'h9E3779B9, ~(32'(la) * 32'h85EBCA6B)};
  endfunction

  // ---------------- emulated 2-way cache ----------------
  logic        c_valid [64][2];
  logic [10:0] c_tag   [64][2];
  logic [63:0] c_data  [64][2];
  logic        c_lru   [64];
  logic [5:0]  c_idx;
  logic [10:0] c_tg;
  logic        c_hit, c_way, fill_way;

  assign c_idx = cache_address[6:1];
  assign c_tg  = cache_address[17:7];

  always_comb begin
    c_hit = 1'b0;
    c_way = 1'b0;
    for (int w = 0; w < 2; w++)
      if (c_valid[c_idx][w] && c_tag[c_idx][w] == c_tg) begin
        c_hit = 1'b1;
        c_way = 1'(w);
      end
    cache_isHit    = c_hit;
    cache_ReadData = cache_address[0] ? c_data[c_idx][c_way][63:32] : c_data[c_idx][c_way][31:0];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 64; s++) begin
        c_valid[s][0] <= 1'b0;
        c_valid[s][1] <= 1'b0;
        c_lru[s]      <= 1'b0;
      end
    end else begin
      if (cache_MEM_R_EN && c_hit) c_lru[c_idx] <= ~c_way;
      if (cache_writeEn) begin
        fill_way = !c_valid[c_idx][0] ? 1'b0 : (!c_valid[c_idx][1] ? 1'b1 : c_lru[c_idx]);
        c_valid[c_idx][fill_way] <= 1'b1;
        c_tag[c_idx][fill_way]   <= c_tg;
        c_data[c_idx][fill_way]  <= cache_WriteData;
        c_lru[c_idx]             <= ~fill_way;
      end
      if (cache_invalidate && c_hit) c_valid[c_idx][c_way] <= 1'b0;
    end
  end

  // ---------------- emulated SRAM controller ----------------
  logic [63:0] sram_mem [int];
  int          lat_cfg = 1;
  int          s_cnt;
  logic        s_rdy_q;
  logic        stray = 1'b0;
  logic        cur_off = 1'b0;
  logic [63:0] s_line;

  assign sram_ready = s_rdy_q | stray;

  always @(posedge clk) begin
    if (rst) begin
      s_cnt      <= 0;
      s_rdy_q    <= 1'b0;
      sram_rdata <= '0;
    end else if ((sram_read_en || sram_write_en) && !s_rdy_q) begin
      if (s_cnt >= lat_cfg - 1) begin
        s_rdy_q <= 1'b1;
        s_cnt   <= 0;
        s_line = sram_mem.exists(int'(sram_address)) ? sram_mem[int'(sram_address)]
                                                      : line_init(int'(sram_address));
        if (sram_read_en) sram_rdata <= s_line;
        else begin
          if (cur_off) s_line[63:32] = sram_wdata;
          else         s_line[31:0]  = sram_wdata;
          sram_mem[int'(sram_address)] = s_line;
        end
      end else s_cnt <= s_cnt + 1;
    end else s_rdy_q <= 1'b0;
  end

  // ---------------- reference model ----------------
  logic [63:0] ref_mem [int];
  int          ref_set [64][$];

  function automatic logic [63:0] ref_get(input int la);
    return ref_mem.exists(la) ? ref_mem[la] : line_init(la);
  endfunction

  function automatic int ref_find(input int la);
    for (int i = 0; i < ref_set[la % 64].size(); i++)
      if (ref_set[la % 64][i] == la) return i;
    return -1;
  endfunction

  task automatic ref_clear();
    for (int s = 0; s < 64; s++) ref_set[s].delete();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    chk({tag, "_strobes"}, 64'({cache_MEM_R_EN, cache_writeEn, cache_invalidate,
                                cache_LRU_update, sram_read_en, sram_write_en}), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata), 64'd0);
  endtask

  task automatic do_load(input logic [31:0] a, input int lat);
    logic [31:0] eff;
    int          la, pos, cyc, exp_stall;
    logic        exp_hit, saw_rd, addr_ok, done;
    logic [63:0] line;
    logic [31:0] exp_word;
    eff      = a - 32'd1024;
    la       = int'(eff[19:3]);
    pos      = ref_find(la);
    exp_hit  = (pos >= 0);
    line     = ref_get(la);
    exp_word = eff[2] ? line[63:32] : line[31:0];
    exp_stall = exp_hit ? 0 : lat + 2;
    lat_cfg  = lat;
    address  = a;
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b1;
    cyc = 0; saw_rd = 1'b0; addr_ok = 1'b1; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (cyc == 0) chk("ld_lookup", 64'(cache_MEM_R_EN), 64'd1);
      if (sram_read_en) begin
        saw_rd = 1'b1;
        if (int'(sram_address) != la) addr_ok = 1'b0;
      end
      if (ready) begin
        done = 1'b1;
        chk("ld_stall", 64'(cyc), 64'(exp_stall));
        chk("ld_rdata", 64'(rdata), 64'(exp_word));
        chk("ld_fill", 64'(cache_writeEn), 64'(!exp_hit));
        chk("ld_sram_rd", 64'(saw_rd), 64'(!exp_hit));
        chk("ld_sram_addr", 64'(addr_ok), 64'd1);
        if (!exp_hit) chk("ld_fill_data", cache_WriteData, line);
      end else begin
        cyc++;
        if (cyc > 80) begin
          chk("ld_timeout", 64'(cyc), 64'(exp_stall));
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    MEM_R_EN = 1'b0;
    if (exp_hit) ref_set[la % 64].delete(pos);
    ref_set[la % 64].push_front(la);
    if (ref_set[la % 64].size() > 2) void'(ref_set[la % 64].pop_back());
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int lat, input logic both);
    logic [31:0] eff;
    int          la, pos, cyc;
    logic        saw_rd, done;
    logic [63:0] line;
    eff      = a - 32'd1024;
    la       = int'(eff[19:3]);
    cur_off  = eff[2];
    lat_cfg  = lat;
    address  = a;
    wdata    = d;
    MEM_W_EN = 1'b1;
    MEM_R_EN = both;
    cyc = 0; saw_rd = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (cyc == 0) chk("st_invalidate", 64'(cache_invalidate), 64'd1);
      if (sram_read_en) saw_rd = 1'b1;
      if (ready) begin
        done = 1'b1;
        chk("st_stall", 64'(cyc), 64'(lat + 1));
        chk("st_wdata", 64'(sram_wdata), 64'(d));
        chk("st_wr_en", 64'(sram_write_en), 64'd1);
        chk("st_addr", 64'(sram_address), 64'(la));
        chk("st_rdata", 64'(rdata), 64'd0);
        chk("st_no_rd", 64'(saw_rd), 64'd0);
      end else begin
        cyc++;
        if (cyc > 80) begin
          chk("st_timeout", 64'(cyc), 64'(lat + 1));
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b0;
    line = ref_get(la);
    if (eff[2]) line[63:32] = d;
    else        line[31:0]  = d;
    ref_mem[la] = line;
    pos = ref_find(la);
    if (pos >= 0) ref_set[la % 64].delete(pos);
  endtask

  initial begin
    logic [31:0] eff, a;
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = '0; wdata = '0;
    ref_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    chk("reset_linebuf", cache_WriteData, 64'd0);
    @(posedge clk); #1;

    // Directed: miss then hit, offset select, write-through, simultaneous request.
    do_load(32'd1032, 3);
    do_load(32'd1032, 1);
    do_load(32'd1036, 2);
    do_store(32'd1032, 32'h12345678, 2, 1'b0);
    do_load(32'd1032, 2);
    do_store(32'd1040, 32'hCAFEF00D, 1, 1'b1);
    do_load(32'd1040, 1);

    // Reset in the middle of a miss.
    lat_cfg = 4; address = 32'd1024 + 32'h200; MEM_R_EN = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rstmiss_stall", 64'(ready), 64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1; MEM_R_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_clear();
    @(negedge clk);
    chk_idle("rstmiss");
    chk("rstmiss_linebuf", cache_WriteData, 64'd0);
    @(posedge clk); #1;
    do_load(32'd1024 + 32'h200, 2);

    // Stray completion pulse while idle.
    stray = 1'b1;
    @(negedge clk);
    chk_idle("stray");
    @(posedge clk); #1;
    stray = 1'b0;
    @(negedge clk);
    chk_idle("stray_after");
    @(posedge clk); #1;
    do_load(32'd1024 + 32'h200, 1);

    // Random traffic over a few conflicting tags in a few sets.
    for (int i = 0; i < 80; i++) begin
      eff = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 3)
          | (32'($urandom_range(0, 1)) << 2);
      a = eff + 32'd1024;
      if ($urandom_range(0, 3) == 0)
        do_store(a, $urandom, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
      else
        do_load(a, int'($urandom_range(1, 4)));
    end

    @(negedge clk);
    chk_idle("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
